// File: rtl/serial_pkg.sv
// ============================================================================
// Module      : serial_pkg
// Description : Shared FSM encoding and default width for bit-serial units.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } serial_state_t;

endpackage : serial_pkg

`default_nettype wire

// File: rtl/fullsubtractor.sv
// ============================================================================
// Module      : fullsubtractor
// Description : One-bit full subtractor, d = x - y - bin with borrow-out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fullsubtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_xy;

   assign w_xy = x ^ y;
   assign d    = w_xy ^ bin;
   assign bout = (~x & y) | (~w_xy & bin);

endmodule : fullsubtractor

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, LSB first, WIDTH cycles per operation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor
   import serial_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);

   localparam int                CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]     LAST = CW'(WIDTH - 1);

   serial_state_t    state_q, state_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] a_q,     a_d;
   logic [WIDTH-1:0] b_q,     b_d;
   logic             br_q,    br_d;
   logic [WIDTH-1:0] res_q,   res_d;
   logic [WIDTH-1:0] diff_q,  diff_d;
   logic             bout_q,  bout_d;

   logic             w_d;
   logic             w_bout;

   fullsubtractor u_fs (
      .x    (a_q[0]),
      .y    (b_q[0]),
      .bin  (br_q),
      .d    (w_d),
      .bout (w_bout)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      b_d     = b_q;
      br_d    = br_q;
      res_d   = res_q;
      diff_d  = diff_q;
      bout_d  = bout_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               br_d    = bin;
               cnt_d   = '0;
               res_d   = '0;
               state_d = SHIFT;
            end else if (state_q == DONE) begin
               state_d = IDLE;
            end
         end
         SHIFT: begin
            // Operands shift right so bit 0 always feeds the subtractor.
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            br_d  = w_bout;
            res_d = {w_d, res_q[WIDTH-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = DONE;
               diff_d  = res_d;
               bout_d  = w_bout;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         br_q    <= 1'b0;
         res_q   <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         br_q    <= br_d;
         res_q   <= res_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = (state_q == DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule : serial_subtractor

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Scoreboard bench for serial_subtractor at WIDTH 8 and 4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       bin8 = 1'b0;
   logic       busy8, done8, bout8;
   logic [7:0] diff8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       bin4 = 1'b0;
   logic       busy4, done4, bout4;
   logic [3:0] diff4;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] exp8[$];
   logic [4:0] exp4[$];

   always #5 clk = ~clk;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
      .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
   );

   serial_subtractor #(.WIDTH(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
      .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
   );

   // Reference: plain integer subtraction, truncated to WIDTH+1 bits.
   function automatic logic [8:0] model8(input int ia, input int ib, input int ibin);
      int r;
      r = ia - ib - ibin;
      return 9'(r);
   endfunction

   function automatic logic [4:0] model4(input int ia, input int ib, input int ibin);
      int r;
      r = ia - ib - ibin;
      return 5'(r);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Scoreboard monitors
   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (exp8.size() == 0) begin
            check("dut8_unexpected_done", 32'd1, 32'd0);
         end else begin
            check("dut8_result", {23'd0, bout8, diff8}, {23'd0, exp8.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && done4) begin
         if (exp4.size() == 0) begin
            check("dut4_unexpected_done", 32'd1, 32'd0);
         end else begin
            check("dut4_result", {27'd0, bout4, diff4}, {27'd0, exp4.pop_front()});
         end
      end
   end

   // Call at a negedge when the DUT will accept on the next posedge.
   task automatic issue8(input logic [7:0] ia, input logic [7:0] ib, input logic ibin);
      a8 = ia; b8 = ib; bin8 = ibin; start8 = 1'b1;
      exp8.push_back(model8(int'(ia), int'(ib), int'(ibin)));
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
   endtask

   task automatic issue4(input logic [3:0] ia, input logic [3:0] ib, input logic ibin);
      a4 = ia; b4 = ib; bin4 = ibin; start4 = 1'b1;
      exp4.push_back(model4(int'(ia), int'(ib), int'(ibin)));
      @(negedge clk);
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); bin4 = 1'($urandom);
   endtask

   task automatic wait_done8(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done8) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_done4(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (done4) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ndone;

      // Reset values
      #12;
      check("reset_busy", {31'd0, busy8}, 32'd0);
      check("reset_done", {31'd0, done8}, 32'd0);
      check("reset_diff_bout", {23'd0, bout8, diff8}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Basic operation with latency and pulse-width checks
      @(negedge clk);
      issue8(8'h5A, 8'h3C, 1'b0);
      for (int i = 0; i < 8; i++) begin
         check("basic_busy_window", {30'd0, busy8, done8}, 32'd2);
         @(negedge clk);
      end
      check("basic_done_cycle", {30'd0, busy8, done8}, 32'd1);
      check("basic_value", {23'd0, bout8, diff8}, 32'h01E);
      @(negedge clk);
      check("basic_done_single", {30'd0, busy8, done8}, 32'd0);
      check("basic_hold", {23'd0, bout8, diff8}, 32'h01E);

      // Underflow cases
      issue8(8'h00, 8'h01, 1'b0);
      wait_done8("underflow0");
      @(negedge clk);
      issue8(8'h80, 8'h80, 1'b1);
      wait_done8("underflow1");
      @(negedge clk);

      // Reset in the middle of SHIFT
      issue8(8'h33, 8'h11, 1'b0);
      @(negedge clk);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      void'(exp8.pop_back());
      #1;
      check("rst_async_busy_done", {30'd0, busy8, done8}, 32'd0);
      check("rst_async_diff_bout", {23'd0, bout8, diff8}, 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (done8) ndone++;
      end
      check("rst_no_done", ndone, 32'd0);
      issue8(8'hC4, 8'h4D, 1'b1);
      wait_done8("post_reset");
      @(negedge clk);

      // Start during SHIFT is ignored
      issue8(8'h77, 8'h22, 1'b1);
      @(negedge clk);
      @(negedge clk);
      start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b0;
      @(negedge clk);
      start8 = 1'b0;
      ndone = 0;
      repeat (15) begin
         if (done8) ndone++;
         @(negedge clk);
      end
      check("ignored_start_one_done", ndone, 32'd1);

      // Back-to-back from the done cycle
      issue8(8'h12, 8'h34, 1'b0);
      wait_done8("b2b_first");
      issue8(8'hFF, 8'h0F, 1'b0);
      check("b2b_no_idle", {31'd0, busy8}, 32'd1);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check("b2b_done_timing", {31'd0, done8}, (k == 8) ? 32'd1 : 32'd0);
      end
      check("b2b_value", {23'd0, bout8, diff8}, 32'h0F0);
      @(negedge clk);

      // Random operations, mixing back-to-back and gaps
      for (int n = 0; n < 40; n++) begin
         issue8(8'($urandom), 8'($urandom), 1'($urandom));
         wait_done8("random");
         if ($urandom_range(0, 1) == 0) begin
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
      end
      repeat (3) @(negedge clk);

      // Exhaustive WIDTH=4
      for (int ia = 0; ia < 16; ia++) begin
         for (int ib = 0; ib < 16; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               issue4(4'(ia), 4'(ib), 1'(ic));
               wait_done4("exhaustive");
               if (((ia + ib + ic) % 3) == 0) @(negedge clk);
            end
         end
      end
      repeat (4) @(negedge clk);

      check("sb8_drained", exp8.size(), 32'd0);
      check("sb4_drained", exp4.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_serial_subtractor

`default_nettype wire
